// File: rtl/sc_collatz_tracker.sv
`default_nettype none
// ============================================================================
// Module   : sc_collatz_tracker
// Brief    : Observes a Collatz datapath's control codes and Reg0 loads;
//            counts total/odd steps, tracks peak value and flags saturation.
//            Peak tracking is compiled in only when SC_COLLATZ_TRACKER_PEAK_EN
//            is defined; otherwise the peak output is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sc_collatz_tracker #(
    parameter int DATAWIDTH_BUS               = 8,
    parameter int DATAWIDTH_ALU_SELECTION     = 3,
    parameter int DATAWIDTH_DECODER_SELECTION = 2,
    parameter int DATAWIDTH_COUNT             = 8
) (
    input  logic                                   SC_COLLATZ_TRACKER_CLOCK_50,
    input  logic                                   SC_COLLATZ_TRACKER_RESET_InHigh,
    input  logic                                   SC_COLLATZ_TRACKER_start_InHigh,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_COLLATZ_TRACKER_aluselection_InBUS,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_COLLATZ_TRACKER_decoderloadselection_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]               SC_COLLATZ_TRACKER_data_InBUS,
    input  logic                                   SC_COLLATZ_TRACKER_ack_InHigh,
    output logic [DATAWIDTH_COUNT-1:0]             SC_COLLATZ_TRACKER_stepcount_OutBUS,
    output logic [DATAWIDTH_COUNT-1:0]             SC_COLLATZ_TRACKER_oddcount_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]               SC_COLLATZ_TRACKER_peak_OutBUS,
    output logic                                   SC_COLLATZ_TRACKER_busy_OutHigh,
    output logic                                   SC_COLLATZ_TRACKER_resultvalid_OutHigh,
    output logic                                   SC_COLLATZ_TRACKER_overflow_OutHigh
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [DATAWIDTH_ALU_SELECTION-1:0]     c_ALU_EVEN  = '0;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0]     c_ALU_ODD   = DATAWIDTH_ALU_SELECTION'(1);
    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] c_LOAD_REG0 = '0;
    localparam logic [DATAWIDTH_COUNT-1:0]             c_COUNT_MAX = '1;
    localparam logic [DATAWIDTH_BUS-1:0]               c_VALUE_ONE = DATAWIDTH_BUS'(1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_clear;
    logic                       w_track_en;
    logic                       w_step_inc;
    logic                       w_odd_inc;
    logic                       w_load;
    logic [DATAWIDTH_COUNT-1:0] r_stepcount;
    logic [DATAWIDTH_COUNT-1:0] r_oddcount;
    logic                       r_overflow;

    always_ff @(posedge SC_COLLATZ_TRACKER_CLOCK_50) begin
        if (SC_COLLATZ_TRACKER_RESET_InHigh) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A start in TRACK restarts the run; that cycle's codes are discarded.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_track_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (SC_COLLATZ_TRACKER_start_InHigh) begin
                    w_state_next = ST_TRACK;
                    w_clear      = 1'b1;
                end
            end
            ST_TRACK: begin
                if (SC_COLLATZ_TRACKER_start_InHigh) begin
                    w_clear = 1'b1;
                end else begin
                    w_track_en = 1'b1;
                    if ((SC_COLLATZ_TRACKER_decoderloadselection_InBUS == c_LOAD_REG0) &&
                        (SC_COLLATZ_TRACKER_data_InBUS == c_VALUE_ONE)) begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (SC_COLLATZ_TRACKER_ack_InHigh) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_step_inc = w_track_en &&
                        ((SC_COLLATZ_TRACKER_aluselection_InBUS == c_ALU_EVEN) ||
                         (SC_COLLATZ_TRACKER_aluselection_InBUS == c_ALU_ODD));
    assign w_odd_inc  = w_track_en && (SC_COLLATZ_TRACKER_aluselection_InBUS == c_ALU_ODD);
    assign w_load     = w_track_en &&
                        (SC_COLLATZ_TRACKER_decoderloadselection_InBUS == c_LOAD_REG0);

    // Counters stick at all-ones; an attempted wrap raises the sticky flag.
    always_ff @(posedge SC_COLLATZ_TRACKER_CLOCK_50) begin
        if (SC_COLLATZ_TRACKER_RESET_InHigh || w_clear) begin
            r_stepcount <= '0;
            r_oddcount  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_step_inc) begin
                if (r_stepcount == c_COUNT_MAX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_stepcount <= r_stepcount + 1'b1;
                end
            end
            if (w_odd_inc) begin
                if (r_oddcount == c_COUNT_MAX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_oddcount <= r_oddcount + 1'b1;
                end
            end
        end
    end

`ifdef SC_COLLATZ_TRACKER_PEAK_EN
    logic [DATAWIDTH_BUS-1:0] r_peak;

    always_ff @(posedge SC_COLLATZ_TRACKER_CLOCK_50) begin
        if (SC_COLLATZ_TRACKER_RESET_InHigh || w_clear) begin
            r_peak <= '0;
        end else if (w_load && (SC_COLLATZ_TRACKER_data_InBUS > r_peak)) begin
            r_peak <= SC_COLLATZ_TRACKER_data_InBUS;
        end
    end

    assign SC_COLLATZ_TRACKER_peak_OutBUS = r_peak;
`else
    logic w_load_unused;
    assign w_load_unused                  = w_load;
    assign SC_COLLATZ_TRACKER_peak_OutBUS = '0;
`endif

    assign SC_COLLATZ_TRACKER_stepcount_OutBUS    = r_stepcount;
    assign SC_COLLATZ_TRACKER_oddcount_OutBUS     = r_oddcount;
    assign SC_COLLATZ_TRACKER_overflow_OutHigh    = r_overflow;
    assign SC_COLLATZ_TRACKER_busy_OutHigh        = (r_state == ST_TRACK);
    assign SC_COLLATZ_TRACKER_resultvalid_OutHigh = (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_sc_collatz_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_collatz_tracker
// Brief    : Self-checking bench; 8-bit and 4-bit counter instances share
//            stimulus and are compared with a trajectory-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_collatz_tracker;

    logic       clk = 1'b0;
    logic       rst, start, ack;
    logic [2:0] alu;
    logic [1:0] lsel;
    logic [7:0] data;

    logic [7:0] step8, odd8, peak8, peak4;
    logic [3:0] step4, odd4;
    logic       busy8, rv8, ovf8, busy4, rv4, ovf4;
    logic [26:0] a8;
    logic [18:0] a4;

    int checks   = 0;
    int failures = 0;
    int traj[$];
    int e_step, e_odd, e_peak;

    always #5 clk = ~clk;

    sc_collatz_tracker #(.DATAWIDTH_COUNT(8)) dut8 (
        .SC_COLLATZ_TRACKER_CLOCK_50(clk),
        .SC_COLLATZ_TRACKER_RESET_InHigh(rst),
        .SC_COLLATZ_TRACKER_start_InHigh(start),
        .SC_COLLATZ_TRACKER_aluselection_InBUS(alu),
        .SC_COLLATZ_TRACKER_decoderloadselection_InBUS(lsel),
        .SC_COLLATZ_TRACKER_data_InBUS(data),
        .SC_COLLATZ_TRACKER_ack_InHigh(ack),
        .SC_COLLATZ_TRACKER_stepcount_OutBUS(step8),
        .SC_COLLATZ_TRACKER_oddcount_OutBUS(odd8),
        .SC_COLLATZ_TRACKER_peak_OutBUS(peak8),
        .SC_COLLATZ_TRACKER_busy_OutHigh(busy8),
        .SC_COLLATZ_TRACKER_resultvalid_OutHigh(rv8),
        .SC_COLLATZ_TRACKER_overflow_OutHigh(ovf8)
    );

    sc_collatz_tracker #(.DATAWIDTH_COUNT(4)) dut4 (
        .SC_COLLATZ_TRACKER_CLOCK_50(clk),
        .SC_COLLATZ_TRACKER_RESET_InHigh(rst),
        .SC_COLLATZ_TRACKER_start_InHigh(start),
        .SC_COLLATZ_TRACKER_aluselection_InBUS(alu),
        .SC_COLLATZ_TRACKER_decoderloadselection_InBUS(lsel),
        .SC_COLLATZ_TRACKER_data_InBUS(data),
        .SC_COLLATZ_TRACKER_ack_InHigh(ack),
        .SC_COLLATZ_TRACKER_stepcount_OutBUS(step4),
        .SC_COLLATZ_TRACKER_oddcount_OutBUS(odd4),
        .SC_COLLATZ_TRACKER_peak_OutBUS(peak4),
        .SC_COLLATZ_TRACKER_busy_OutHigh(busy4),
        .SC_COLLATZ_TRACKER_resultvalid_OutHigh(rv4),
        .SC_COLLATZ_TRACKER_overflow_OutHigh(ovf4)
    );

    assign a8 = {step8, odd8, peak8, busy8, rv8, ovf8};
    assign a4 = {step4, odd4, peak4, busy4, rv4, ovf4};

    // Reference: outputs from step/odd totals and peak of the trajectory.
    function automatic logic [7:0] peak_of(input int pk);
`ifdef SC_COLLATZ_TRACKER_PEAK_EN
        return 8'(pk);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [26:0] exp8(input int st, input int od, input int pk,
                                         input logic b, input logic v);
        return {8'(st > 255 ? 255 : st), 8'(od > 255 ? 255 : od), peak_of(pk),
                b, v, (st > 255 || od > 255)};
    endfunction

    function automatic logic [18:0] exp4(input int st, input int od, input int pk,
                                         input logic b, input logic v);
        return {4'(st > 15 ? 15 : st), 4'(od > 15 ? 15 : od), peak_of(pk),
                b, v, (st > 15 || od > 15)};
    endfunction

    task automatic build_traj(input int n);
        int v;
        v = n;
        traj.delete();
        traj.push_back(v);
        while (v != 1) begin
            v = (v % 2 == 0) ? v / 2 : 3 * v + 1;
            traj.push_back(v);
        end
        e_step = traj.size() - 1;
        e_odd  = 0;
        e_peak = 0;
        foreach (traj[i]) begin
            if (i < traj.size() - 1 && traj[i] % 2 == 1) e_odd++;
            if (traj[i] > e_peak) e_peak = traj[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        ack   = 1'b0;
        alu   = 3'($urandom_range(2, 7));
        lsel  = 2'($urandom_range(1, 3));
        data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        idle_inputs();
        start = 1'b1;
        cycle();
        idle_inputs();
    endtask

    // Drives the full load sequence for n; noise inserts no-op cycles.
    task automatic feed(input int n, input bit noise);
        build_traj(n);
        alu  = 3'($urandom_range(2, 7));
        lsel = 2'b00;
        data = 8'(traj[0]);
        cycle();
        for (int i = 1; i < traj.size(); i++) begin
            if (noise && ($urandom % 3 == 0)) begin
                idle_inputs();
                cycle();
            end
            alu  = (traj[i-1] % 2 == 1) ? 3'b001 : 3'b000;
            lsel = 2'b00;
            data = 8'(traj[i]);
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        checks += 2;
        if (a8 !== 27'd0) begin failures++; $display("FAIL reset dut8 got=%h exp=%h", a8, 27'd0); end
        if (a4 !== 19'd0) begin failures++; $display("FAIL reset dut4 got=%h exp=%h", a4, 19'd0); end
        rst = 1'b0;
    endtask

    task automatic test_n6();
        pulse_start();
        checks++;
        if (a8 !== exp8(0, 0, 0, 1, 0)) begin failures++; $display("FAIL n6_busy got=%h exp=%h", a8, exp8(0, 0, 0, 1, 0)); end
        feed(6, 0);
        checks += 2;
        if (a8 !== exp8(8, 2, 16, 0, 1)) begin failures++; $display("FAIL n6_result dut8 got=%h exp=%h", a8, exp8(8, 2, 16, 0, 1)); end
        if (a4 !== exp4(8, 2, 16, 0, 1)) begin failures++; $display("FAIL n6_result dut4 got=%h exp=%h", a4, exp4(8, 2, 16, 0, 1)); end
        ack = 1'b1;
        cycle();
        idle_inputs();
        checks++;
        if (a8 !== exp8(8, 2, 16, 0, 0)) begin failures++; $display("FAIL n6_ack got=%h exp=%h", a8, exp8(8, 2, 16, 0, 0)); end
    endtask

    task automatic test_n7_hold();
        pulse_start();
        feed(7, 1);
        checks += 2;
        if (a8 !== exp8(16, 5, 52, 0, 1)) begin failures++; $display("FAIL n7_result dut8 got=%h exp=%h", a8, exp8(16, 5, 52, 0, 1)); end
        if (a4 !== exp4(16, 5, 52, 0, 1)) begin failures++; $display("FAIL n7_sat dut4 got=%h exp=%h", a4, exp4(16, 5, 52, 0, 1)); end
        start = 1'b1;
        lsel  = 2'b00;
        data  = 8'd200;
        alu   = 3'b001;
        cycle();
        idle_inputs();
        cycle();
        checks += 2;
        if (a8 !== exp8(16, 5, 52, 0, 1)) begin failures++; $display("FAIL hold_start dut8 got=%h exp=%h", a8, exp8(16, 5, 52, 0, 1)); end
        if (a4 !== exp4(16, 5, 52, 0, 1)) begin failures++; $display("FAIL hold_start dut4 got=%h exp=%h", a4, exp4(16, 5, 52, 0, 1)); end
    endtask

    task automatic test_start_ack_same();
        start = 1'b1;
        ack   = 1'b1;
        cycle();
        idle_inputs();
        checks++;
        if (a8 !== exp8(16, 5, 52, 0, 0)) begin failures++; $display("FAIL start_ack got=%h exp=%h", a8, exp8(16, 5, 52, 0, 0)); end
        ack = 1'b1;
        cycle();
        idle_inputs();
        checks += 2;
        if (a8 !== exp8(16, 5, 52, 0, 0)) begin failures++; $display("FAIL ack_idle dut8 got=%h exp=%h", a8, exp8(16, 5, 52, 0, 0)); end
        if (a4 !== exp4(16, 5, 52, 0, 0)) begin failures++; $display("FAIL ack_idle dut4 got=%h exp=%h", a4, exp4(16, 5, 52, 0, 0)); end
        pulse_start();
        ack = 1'b1;
        cycle();
        idle_inputs();
        checks += 2;
        if (a8 !== exp8(0, 0, 0, 1, 0)) begin failures++; $display("FAIL restart_clear got=%h exp=%h", a8, exp8(0, 0, 0, 1, 0)); end
        if (a4 !== exp4(0, 0, 0, 1, 0)) begin failures++; $display("FAIL ack_track got=%h exp=%h", a4, exp4(0, 0, 0, 1, 0)); end
        feed(1, 0);
        checks++;
        if (a8 !== exp8(0, 0, 1, 0, 1)) begin failures++; $display("FAIL n1_result got=%h exp=%h", a8, exp8(0, 0, 1, 0, 1)); end
        ack = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_restart_track();
        pulse_start();
        alu  = 3'b111;
        lsel = 2'b00;
        data = 8'd7;
        cycle();
        for (int i = 0; i < 16; i++) begin
            alu  = 3'b000;
            lsel = 2'b11;
            cycle();
        end
        idle_inputs();
        checks += 2;
        if (a8 !== exp8(16, 0, 7, 1, 0)) begin failures++; $display("FAIL raw_steps dut8 got=%h exp=%h", a8, exp8(16, 0, 7, 1, 0)); end
        if (a4 !== exp4(16, 0, 7, 1, 0)) begin failures++; $display("FAIL raw_steps dut4 got=%h exp=%h", a4, exp4(16, 0, 7, 1, 0)); end
        pulse_start();
        checks++;
        if (a4 !== exp4(0, 0, 0, 1, 0)) begin failures++; $display("FAIL track_restart got=%h exp=%h", a4, exp4(0, 0, 0, 1, 0)); end
        feed(6, 1);
        checks++;
        if (a8 !== exp8(8, 2, 16, 0, 1)) begin failures++; $display("FAIL restart_n6 got=%h exp=%h", a8, exp8(8, 2, 16, 0, 1)); end
        ack = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        build_traj(7);
        pulse_start();
        alu  = 3'b111;
        lsel = 2'b00;
        data = 8'(traj[0]);
        cycle();
        for (int i = 1; i < 6; i++) begin
            alu  = (traj[i-1] % 2 == 1) ? 3'b001 : 3'b000;
            data = 8'(traj[i]);
            cycle();
        end
        rst   = 1'b1;
        start = 1'b1;
        ack   = 1'b1;
        cycle();
        rst = 1'b0;
        idle_inputs();
        checks += 2;
        if (a8 !== 27'd0) begin failures++; $display("FAIL reset_mid dut8 got=%h exp=%h", a8, 27'd0); end
        if (a4 !== 19'd0) begin failures++; $display("FAIL reset_mid dut4 got=%h exp=%h", a4, 19'd0); end
        pulse_start();
        feed(6, 1);
        checks++;
        if (a8 !== exp8(8, 2, 16, 0, 1)) begin failures++; $display("FAIL post_reset_n6 got=%h exp=%h", a8, exp8(8, 2, 16, 0, 1)); end
        ack = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 20; r++) begin
            for (int t = 0; t < 100; t++) begin
                n = $urandom_range(1, 120);
                build_traj(n);
                if (e_peak <= 255) break;
            end
            if (e_peak > 255) n = 6;
            for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
            pulse_start();
            feed(n, 1);
            checks += 2;
            if (a8 !== exp8(e_step, e_odd, e_peak, 0, 1)) begin failures++; $display("FAIL rand_n%0d dut8 got=%h exp=%h", n, a8, exp8(e_step, e_odd, e_peak, 0, 1)); end
            if (a4 !== exp4(e_step, e_odd, e_peak, 0, 1)) begin failures++; $display("FAIL rand_n%0d dut4 got=%h exp=%h", n, a4, exp4(e_step, e_odd, e_peak, 0, 1)); end
            for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
            ack   = 1'b1;
            start = 1'($urandom % 2);
            cycle();
            idle_inputs();
            checks++;
            if (a8 !== exp8(e_step, e_odd, e_peak, 0, 0)) begin failures++; $display("FAIL rand_ack_n%0d got=%h exp=%h", n, a8, exp8(e_step, e_odd, e_peak, 0, 0)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_n6();
        test_n7_hold();
        test_start_ack_same();
        test_restart_track();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
